// File: rtl/pulse_analyzer.sv
// Measures period and high time of an asynchronous waveform between rising edges; flags stuck levels.
// Latency: meas_valid rises 3 clk edges after the edge that first samples a new rising edge of sig_in.
// Backpressure: none; results are a one-cycle pulse and overwrite the previous measurement.
module pulse_analyzer #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             meas_valid,
    output logic             locked,
    output logic             stuck_hi,
    output logic             stuck_lo
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    state_t           state;
    state_t           state_nxt;
    logic             sync1;
    logic             s_q;
    logic             s_d;
    logic             rise;
    logic             timeout;
    logic             capture;
    logic             restart;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] tcnt;
    logic             valid_pend;
    logic             match_pend;
    logic             prev_ok;

    assign rise = s_q & ~s_d;

    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        capture   = 1'b0;
        restart   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = MEASURE;
                    restart   = 1'b1;
                end else if (tcnt == TO_CNT) begin
                    state_nxt = STUCK;
                    timeout   = 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    capture = 1'b1;
                    restart = 1'b1;
                end else if (tcnt == TO_CNT) begin
                    state_nxt = STUCK;
                    timeout   = 1'b1;
                end
            end
            STUCK: begin
                if (rise) begin
                    state_nxt = MEASURE;
                    restart   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sync1 <= 1'b0;
            s_q   <= 1'b0;
            s_d   <= 1'b0;
        end else begin
            state <= state_nxt;
            sync1 <= sig_in;
            s_q   <= sync1;
            s_d   <= s_q;
        end
    end

    // The rise cycle itself is a high sample, hence hcnt restarts at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
            hcnt <= '0;
            tcnt <= '0;
        end else if (restart) begin
            pcnt <= CNT_W'(1);
            hcnt <= CNT_W'(1);
            tcnt <= CNT_W'(1);
        end else if (state == MEASURE && !timeout) begin
            pcnt <= pcnt + CNT_W'(1);
            hcnt <= hcnt + CNT_W'(s_q);
            tcnt <= tcnt + CNT_W'(1);
        end else if (state == IDLE && !timeout) begin
            tcnt <= tcnt + CNT_W'(1);
        end
    end

    // Comparison against the previous pair is resolved at capture and applied with meas_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            meas_period <= '0;
            meas_high   <= '0;
            meas_valid  <= 1'b0;
            valid_pend  <= 1'b0;
            match_pend  <= 1'b0;
            prev_ok     <= 1'b0;
            locked      <= 1'b0;
            stuck_hi    <= 1'b0;
            stuck_lo    <= 1'b0;
        end else begin
            meas_valid <= valid_pend;
            valid_pend <= capture;
            if (capture) begin
                meas_period <= pcnt;
                meas_high   <= hcnt;
                match_pend  <= prev_ok && (pcnt == meas_period) && (hcnt == meas_high);
                prev_ok     <= 1'b1;
            end
            if (valid_pend) begin
                locked <= match_pend;
            end
            if (timeout) begin
                locked   <= 1'b0;
                prev_ok  <= 1'b0;
                stuck_hi <= s_q;
                stuck_lo <= ~s_q;
            end else if (state == STUCK) begin
                if (rise) begin
                    prev_ok  <= 1'b0;
                    stuck_hi <= 1'b0;
                    stuck_lo <= 1'b0;
                end else begin
                    stuck_hi <= s_q;
                    stuck_lo <= ~s_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_analyzer.sv
// Bench for pulse_analyzer: waveform driver with sample-history reference model, scoreboard monitor.
// Expected measurements are derived from rising-edge indices and sums over the sample history.
module tb_pulse_analyzer;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] meas_period;
    logic [CNT_W-1:0] meas_high;
    logic             meas_valid;
    logic             locked;
    logic             stuck_hi;
    logic             stuck_lo;

    pulse_analyzer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .sig_in     (sig_in),
        .meas_period(meas_period),
        .meas_high  (meas_high),
        .meas_valid (meas_valid),
        .locked     (locked),
        .stuck_hi   (stuck_hi),
        .stuck_lo   (stuck_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int per;
        int hi;
        int lk;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    int   samp[$];
    int   last_rise = -1;
    bit   last_v = 1'b0;
    bit   pair_ok = 1'b0;
    int   pp = 0;
    int   ph = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // One sample of sig_in; a rising edge closes the period that began at the previous rise.
    task automatic drive_cycle(input bit v);
        int   i;
        exp_t e;
        sig_in = v;
        i = samp.size();
        samp.push_back(int'(v));
        if (v && !last_v) begin
            if (last_rise >= 0 && (i - last_rise) <= TIMEOUT) begin
                e.per = i - last_rise;
                e.hi  = 0;
                for (int k = last_rise; k < i; k++) e.hi += samp[k];
                e.lk  = (pair_ok && e.per == pp && e.hi == ph) ? 1 : 0;
                e.cyc = cyc + 4;
                exp_q.push_back(e);
                pp = e.per;
                ph = e.hi;
                pair_ok = 1'b1;
            end else begin
                pair_ok = 1'b0;
            end
            last_rise = i;
        end
        last_v = v;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_period(input int p, input int h);
        for (int k = 0; k < p; k++) drive_cycle(k < h);
    endtask

    task automatic hold(input bit v, input int n);
        for (int k = 0; k < n; k++) drive_cycle(v);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        sig_in = 1'b0;
        @(posedge clk);
        #1;
        check("rst_meas_period", int'(meas_period), 0);
        check("rst_meas_high", int'(meas_high), 0);
        check("rst_meas_valid", int'(meas_valid), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_stuck_hi", int'(stuck_hi), 0);
        check("rst_stuck_lo", int'(stuck_lo), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        samp.delete();
        exp_q.delete();
        last_rise = -1;
        last_v    = 1'b0;
        pair_ok   = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            checks++;
            if (stuck_hi && stuck_lo) begin
                failures++;
                $display("FAIL stuck_exclusive: got hi=1 lo=1 expected at most one set (cycle %0d)", cyc);
            end
            if (meas_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: got meas_valid=1 period=%0d high=%0d expected no valid (cycle %0d)",
                             meas_period, meas_high, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("meas_period", int'(meas_period), e.per);
                    check("meas_high", int'(meas_high), e.hi);
                    check("locked_on_valid", int'(locked), e.lk);
                    check("valid_latency_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int p;
        int h;
        int lp;
        int lh;
        @(posedge clk);
        #1;
        do_reset();

        // Low after reset: stuck_lo only after the timeout, then a 6/3 waveform releases it.
        hold(1'b0, 10);
        check("idle_stuck_lo_early", int'(stuck_lo), 0);
        hold(1'b0, 10);
        check("idle_stuck_lo", int'(stuck_lo), 1);
        check("idle_stuck_hi", int'(stuck_hi), 0);
        drive_period(6, 3);
        check("stuck_lo_cleared", int'(stuck_lo), 0);
        repeat (3) drive_period(6, 3);

        repeat (5) drive_period(4, 2);
        check("locked_4_2", int'(locked), 1);
        repeat (3) drive_period(6, 5);
        check("locked_6_5", int'(locked), 1);

        repeat (6) drive_period(2, 1);
        check("min_period_stuck_hi", int'(stuck_hi), 0);
        check("min_period_stuck_lo", int'(stuck_lo), 0);

        lp = 4;
        lh = 2;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(9, 0) < 3) begin
                p = lp;
                h = lh;
            end else begin
                p = $urandom_range(TIMEOUT, 2);
                h = $urandom_range(p - 1, 1);
            end
            drive_period(p, h);
            lp = p;
            lh = h;
        end

        // Locked at 5/3, then held high until stuck_hi.
        repeat (4) drive_period(5, 3);
        check("locked_5_3", int'(locked), 1);
        hold(1'b1, 25);
        check("held_stuck_hi", int'(stuck_hi), 1);
        check("held_stuck_lo", int'(stuck_lo), 0);
        check("held_locked", int'(locked), 0);
        check("held_meas_period", int'(meas_period), 5);
        check("held_meas_high", int'(meas_high), 3);
        hold(1'b0, 2);
        drive_period(5, 3);
        check("stuck_hi_cleared", int'(stuck_hi), 0);
        repeat (3) drive_period(5, 3);

        // Gaps one past the timeout never produce a measurement.
        repeat (3) drive_period(TIMEOUT + 1, 1);
        repeat (3) drive_period(4, 2);
        repeat (4) drive_period(4, 2);

        drive_cycle(1'b1);
        drive_cycle(1'b1);
        hold(1'b0, 3);
        check("pre_reset_locked", int'(locked), 1);
        check("pre_reset_queue_empty", exp_q.size(), 0);
        do_reset();
        repeat (3) drive_period(4, 2);
        check("post_reset_locked", int'(locked), 1);

        hold(1'b0, 6);
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
